// File: rtl/if_de_stage_pkg.sv
// Shared fetch/decode constants.
// Imported by the fetch stage and the downstream pipeline register.
package if_de_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h4000_0000;
  localparam logic [XLEN-1:0] ILEN_B = 32'd4;
endpackage

// File: rtl/if_de_stage_if.sv
// Fetch-stage bus: pipeline controls, IMEM read port, decode outputs.
// master is the fetch stage, slave is its environment.
interface if_de_stage_if;
  import if_de_stage_pkg::*;
  logic            stall;
  logic            interlock;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] imem_addr;
  logic            imem_en;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr_D;
  logic [XLEN-1:0] PC_D;
  logic [XLEN-1:0] PC_4_D;
  logic            valid_D;

  modport master (
    input  stall, interlock, taken, target, imem_rdata,
    output imem_addr, imem_en, instr_D, PC_D, PC_4_D, valid_D
  );

  modport slave (
    output stall, interlock, taken, target, imem_rdata,
    input  imem_addr, imem_en, instr_D, PC_D, PC_4_D, valid_D
  );
endinterface

// File: rtl/if_de_stage_hold_buffer.sv
// Holds the fetched word while the read port is disabled.
// Also selects the instruction presented to decode.
module if_hold_buffer
  import if_de_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_en,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_D
);
  logic            buf_valid;
  logic [XLEN-1:0] buf_instr;
  logic            capture;

  assign capture = ~imem_en & fetch_valid & ~buf_valid;

  if_de_reg #(.W(1), .RST(1'b0)) u_buf_valid (
    .clk (clk),
    .rst (rst),
    .en  (imem_en | capture),
    .d   (capture),
    .q   (buf_valid)
  );

  if_de_reg #(.W(XLEN), .RST(NOP_INSTR)) u_buf_instr (
    .clk (clk),
    .rst (rst),
    .en  (capture),
    .d   (imem_rdata),
    .q   (buf_instr)
  );

  // decode word: held copy, then live read data, then NOP
  always_comb begin
    instr_D = NOP_INSTR;
    if (buf_valid) instr_D = buf_instr;
    else if (fetch_valid) instr_D = imem_rdata;
  end
endmodule

// File: rtl/if_de_stage_reg.sv
// Async-reset register cell with load enable.
// Reset value is a parameter so every state bit uses one cell.
module if_de_reg #(
  parameter int W = 1,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // load d when enabled, else hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST;
    else if (en) q <= d;
  end
endmodule

// File: rtl/if_de_stage.sv
// Fetch stage: PC generation, IMEM read port, decode outputs.
// Honours stall > taken > interlock like the downstream register.
module if_de_stage
  import if_de_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input logic          clk,
  input logic          rst,
  if_de_stage_if.master bus
);
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] next_addr;
  logic            fetch_valid;
  logic            hold;
  logic            redirect;
  logic            fetch_en;

  assign hold     = bus.stall | bus.interlock;
  assign redirect = bus.taken & ~bus.stall;
  assign fetch_en = redirect | ~hold;
  assign pc_inc   = pc_q + ILEN_B;

  // next read address: redirect, then hold, then sequential
  always_comb begin
    next_addr = pc_inc;
    if (redirect) next_addr = bus.target;
    else if (hold) next_addr = pc_q;
  end

  if_de_reg #(.W(XLEN), .RST(RESET_PC - ILEN_B)) u_pc (
    .clk (clk),
    .rst (rst),
    .en  (fetch_en),
    .d   (next_addr),
    .q   (pc_q)
  );

  if_de_reg #(.W(1), .RST(1'b0)) u_fetch_valid (
    .clk (clk),
    .rst (rst),
    .en  (fetch_en),
    .d   (1'b1),
    .q   (fetch_valid)
  );

  if_hold_buffer #(.NOP_INSTR(NOP_INSTR)) u_hold (
    .clk         (clk),
    .rst         (rst),
    .imem_en     (fetch_en),
    .fetch_valid (fetch_valid),
    .imem_rdata  (bus.imem_rdata),
    .instr_D     (bus.instr_D)
  );

  assign bus.imem_addr = next_addr;
  assign bus.imem_en   = fetch_en;
  assign bus.PC_D      = pc_q;
  assign bus.PC_4_D    = pc_inc;
  assign bus.valid_D   = fetch_valid;
endmodule

// File: tb/tb_if_de_stage.sv
// Directed bench for if_de_stage.
// Memory word at address a is ~a; disabled port returns DEADBEEF.
module tb_if_de_stage;
  logic clk = 1'b0;
  logic rst;

  if_de_stage_if bus ();

  if_de_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // synchronous read port, junk when disabled
  always @(posedge clk)
    bus.imem_rdata <= bus.imem_en ? ~bus.imem_addr : 32'hDEAD_BEEF;

  typedef struct {
    logic        st;
    logic        il;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] addr;
    logic        en;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, e);
    end
  endtask

  task automatic add(input logic st, input logic il, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] addr,
                     input logic en, input logic [31:0] pc,
                     input logic [31:0] instr, input logic valid);
    vec_t v;
    v.st = st; v.il = il; v.tk = tk; v.tgt = tgt;
    v.addr = addr; v.en = en; v.pc = pc;
    v.instr = instr; v.valid = valid;
    vq.push_back(v);
  endtask

  task automatic chk_out(input string n, input logic [31:0] addr,
                         input logic en, input logic [31:0] pc,
                         input logic [31:0] instr, input logic valid);
    chk({n, " addr"}, bus.imem_addr, addr);
    chk({n, " en"}, {31'd0, bus.imem_en}, {31'd0, en});
    chk({n, " pc"}, bus.PC_D, pc);
    chk({n, " pc4"}, bus.PC_4_D, pc + 32'd4);
    chk({n, " instr"}, bus.instr_D, instr);
    chk({n, " valid"}, {31'd0, bus.valid_D}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.interlock = 1'b0;
    bus.taken = 1'b0;
    bus.target = 32'd0;

    // sequential fetch from reset
    for (int k = 0; k <= 8; k++)
      add(0, 0, 0, 0, 32'h4000_0000 + 32'(4 * k), 1,
          32'h3FFF_FFFC + 32'(4 * k),
          (k == 0) ? 32'h0000_0013 : ~(32'h3FFF_FFFC + 32'(4 * k)),
          k != 0);
    // stall 3 cycles, port returns junk while disabled
    add(1, 0, 0, 0, 32'h4000_0020, 0, 32'h4000_0020, 32'hBFFF_FFDF, 1);
    add(1, 0, 0, 0, 32'h4000_0020, 0, 32'h4000_0020, 32'hBFFF_FFDF, 1);
    add(1, 0, 0, 0, 32'h4000_0020, 0, 32'h4000_0020, 32'hBFFF_FFDF, 1);
    add(0, 0, 0, 0, 32'h4000_0024, 1, 32'h4000_0020, 32'hBFFF_FFDF, 1);
    add(0, 0, 0, 0, 32'h4000_0028, 1, 32'h4000_0024, 32'hBFFF_FFDB, 1);
    // redirect, wrong-path word stays visible
    add(0, 0, 1, 32'h1000_0010, 32'h1000_0010, 1, 32'h4000_0028,
        32'hBFFF_FFD7, 1);
    add(0, 0, 0, 0, 32'h1000_0014, 1, 32'h1000_0010, 32'hEFFF_FFEF, 1);
    // taken under stall is ignored until stall drops
    add(1, 0, 1, 32'h2000_0000, 32'h1000_0014, 0, 32'h1000_0014,
        32'hEFFF_FFEB, 1);
    add(1, 0, 1, 32'h2000_0000, 32'h1000_0014, 0, 32'h1000_0014,
        32'hEFFF_FFEB, 1);
    add(0, 0, 1, 32'h2000_0000, 32'h2000_0000, 1, 32'h1000_0014,
        32'hEFFF_FFEB, 1);
    add(0, 0, 0, 0, 32'h2000_0004, 1, 32'h2000_0000, 32'hDFFF_FFFF, 1);
    // wrap from 0xFFFF_FFFC
    add(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 32'h2000_0004,
        32'hDFFF_FFFB, 1);
    add(0, 0, 0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_0003, 1);
    add(0, 0, 0, 0, 32'h0000_0004, 1, 32'h0000_0000, 32'hFFFF_FFFF, 1);
    // redirect beats interlock
    add(0, 1, 1, 32'h3000_0000, 32'h3000_0000, 1, 32'h0000_0004,
        32'hFFFF_FFFB, 1);
    add(0, 0, 0, 0, 32'h3000_0004, 1, 32'h3000_0000, 32'hCFFF_FFFF, 1);
    // interlock hold
    add(0, 1, 0, 0, 32'h3000_0004, 0, 32'h3000_0004, 32'hCFFF_FFFB, 1);
    add(0, 1, 0, 0, 32'h3000_0004, 0, 32'h3000_0004, 32'hCFFF_FFFB, 1);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_out("reset", 32'h4000_0000, 1, 32'h3FFF_FFFC, 32'h0000_0013, 0);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      bus.stall = vq[i].st;
      bus.interlock = vq[i].il;
      bus.taken = vq[i].tk;
      bus.target = vq[i].tgt;
      #1;
      chk_out($sformatf("v%0d", i), vq[i].addr, vq[i].en, vq[i].pc,
              vq[i].instr, vq[i].valid);
      @(negedge clk);
    end

    // third interlock cycle, then async reset mid-hold
    bus.taken = 1'b0;
    #1;
    chk_out("il3", 32'h3000_0004, 0, 32'h3000_0004, 32'hCFFF_FFFB, 1);
    bus.interlock = 1'b0;
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 32'h4000_0000, 1, 32'h3FFF_FFFC, 32'h0000_0013, 0);
    @(negedge clk);

    // hold straight after reset captures nothing
    rst = 1'b0;
    bus.stall = 1'b1;
    #1;
    chk_out("h0a", 32'h3FFF_FFFC, 0, 32'h3FFF_FFFC, 32'h0000_0013, 0);
    @(negedge clk);
    #1;
    chk_out("h0b", 32'h3FFF_FFFC, 0, 32'h3FFF_FFFC, 32'h0000_0013, 0);
    bus.stall = 1'b0;
    #1;
    chk_out("h0c", 32'h4000_0000, 1, 32'h3FFF_FFFC, 32'h0000_0013, 0);
    @(negedge clk);
    #1;
    chk_out("h0d", 32'h4000_0004, 1, 32'h4000_0000, 32'hBFFF_FFFF, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_de_stage.md
Name: if_de_stage

Overview:
Fetch stage that sits directly upstream of the decode/execute pipeline register. It generates the PC, drives the synchronous IMEM/BIOS read port (1-cycle read latency) and presents the fetched instruction, PC and PC+4 to decode. It honours the same global stall, load-use interlock and branch-redirect controls as the downstream pipeline register, holding its state or redirecting as required. A hold buffer keeps the decode-side instruction stable while the read port is disabled.

Parameters:
RESET_PC, 32'h4000_0000, first instruction address after reset (BIOS base)
NOP_INSTR, 32'h0000_0013, instruction presented to decode when no valid fetch exists (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
stall  input  1  global stall; freezes the whole stage
interlock  input  1  load-use hazard from decode; hold PC and decode instruction
taken  input  1  redirect from EX (branch taken or jump)
target  input  32  redirect address, valid with taken
imem_addr  output  32  read address to IMEM/BIOS, combinational
imem_en  output  1  read enable to IMEM/BIOS, combinational
imem_rdata  input  32  read data for the address issued on the previous cycle
instr_D  output  32  instruction to decode
PC_D  output  32  address of instr_D
PC_4_D  output  32  PC_D + 4
valid_D  output  1  instr_D comes from a real fetch

Behaviour:
- State registers: pc_q (32), address issued last cycle; fetch_valid (1), imem_rdata corresponds to pc_q; buf_valid (1) and buf_instr (32), the held instruction.
- Reset is async. On reset: pc_q = RESET_PC-4, fetch_valid = 0, buf_valid = 0, buf_instr = NOP_INSTR. Outputs during reset: instr_D = NOP_INSTR, valid_D = 0, PC_D = RESET_PC-4, PC_4_D = RESET_PC, imem_addr = RESET_PC, imem_en = 1.
- hold = stall | interlock. redirect = taken & ~stall. Priority: stall > taken > interlock, matching the downstream register.
- imem_addr: target if redirect; otherwise pc_q if hold; otherwise pc_q+4. All arithmetic is mod 2^32, so wrap from 0xFFFF_FFFC goes to 0.
- imem_en = redirect | ~hold.
- Clock edge with imem_en = 1: pc_q <= imem_addr, fetch_valid <= 1, buf_valid <= 0.
- Clock edge with imem_en = 0: pc_q holds, fetch_valid holds. If fetch_valid and ~buf_valid, then buf_instr <= imem_rdata and buf_valid <= 1; otherwise the buffer holds.
- Decode outputs, combinational from state:
  - instr_D = buf_instr if buf_valid; else imem_rdata if fetch_valid; else NOP_INSTR.
  - valid_D = fetch_valid.
  - PC_D = pc_q.
  - PC_4_D = pc_q + 4.
- Latency: an address issued in cycle t appears on instr_D/PC_D in cycle t+1.
- The read port output is not guaranteed stable while imem_en = 0. The buffer therefore captures it on the first held edge, and instr_D is sourced from the buffer for the rest of the hold.
- Wrong-path instruction on the redirect cycle: it is left visible on instr_D. The downstream register bubbles it because taken is asserted. No kill logic is needed here.
- taken during stall: ignored. EX is frozen, so taken re-presents after the stall.
- taken with interlock (no stall): redirect wins; buffer cleared at the edge.
- Hold while fetch_valid = 0 (right after reset): nothing is captured; instr_D stays NOP_INSTR.
- Reset asserted mid-hold: all state returns to reset values immediately, including the buffer.

Decomposition:
- Shared package holds NOP_INSTR, the RESET_PC default and the 32-bit XLEN constant; the downstream register uses the same NOP.
- pc_q, fetch_valid and buf_valid/buf_instr are instances of the team's existing async-reset register cell.
- One natural sub-module: if_hold_buffer (capture/hold of imem_rdata plus the instr_D mux).

Test Plan:
- Reset release, RESET_PC = 0x4000_0000 → cycle 0: imem_addr = 0x4000_0000, valid_D = 0, instr_D = 0x0000_0013. Cycle 1: PC_D = 0x4000_0000, instr_D = mem[0x4000_0000], imem_addr = 0x4000_0004.
- 8 cycles with no hold → imem_addr increments by 4 each cycle and PC_D trails imem_addr by one cycle. Sequential fetch from pc_q = 0xFFFF_FFFC → next imem_addr = 0x0000_0000.
- stall for 3 cycles, with imem_rdata driven to 0xDEAD_BEEF while imem_en = 0 → instr_D holds the original word, PC_D is frozen, imem_en = 0. On release, imem_addr = PC_D+4 and buf_valid clears.
- taken = 1, target = 0x1000_0010 with no stall → imem_addr = 0x1000_0010 in the same cycle. Next cycle PC_D = 0x1000_0010, valid_D = 1, buffer empty.
- taken = 1 together with stall = 1 → imem_en = 0, imem_addr = pc_q, no redirect. When stall drops with taken still high → redirect occurs.
- interlock for 1 cycle, then async rst pulse mid-hold → PC_D/instr_D held through the interlock. On rst: immediately instr_D = 0x13, valid_D = 0, imem_addr = RESET_PC.
